// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core types, including the retire record and trace entry layout
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int TRACE_SEQ_W = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
    logic            mem_read;
  } retire_rec_t;

  typedef struct packed {
    retire_rec_t            rec;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_entry_t;

  localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_fifo_mem.sv
// rtl/trace_fifo_mem.sv - trace entry storage, synchronous write and asynchronous read
module trace_fifo_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Cleared on reset so the head outputs read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - sequence-stamped retire trace FIFO with drop accounting
module retire_trace_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clear_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     mem_wrt_i,
  input  logic                     mem_read_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic [XLEN-1:0]          trace_instr_o,
  output logic [4:0]               trace_reg_addr_o,
  output logic [XLEN-1:0]          trace_reg_data_o,
  output logic [XLEN-1:0]          trace_mem_addr_o,
  output logic [XLEN-1:0]          trace_mem_data_o,
  output logic                     trace_mem_wrt_o,
  output logic                     trace_mem_read_o,
  output logic [TRACE_SEQ_W-1:0]   trace_seq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [DROP_W-1:0]        drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [TRACE_SEQ_W-1:0] seq;
  logic                   overflow;
  logic [DROP_W-1:0]      drop_cnt;
  logic                   full, pop, push, drop;
  logic [ENTRY_W-1:0]     wr_bits, head_bits;
  trace_entry_t           head;

  assign full = (count == FULL_CNT);
  assign pop  = (count != '0) && trace_ready_i;
  assign push = update_i && !clear_i && (!full || pop);
  assign drop = update_i && full && !pop && !clear_i;

  assign wr_bits = {pc_i, instr_i, reg_addr_i, reg_data_i, mem_addr_i, mem_data_i,
                    mem_wrt_i, mem_read_i, seq};

  trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk_i),
    .rst_n   (rstn_i),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_bits),
    .rd_addr (rd_ptr),
    .rd_data (head_bits)
  );

  // seq advances on every retire, accepted or dropped, so gaps mark losses.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (update_i) seq <= seq + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign head             = head_bits;
  assign trace_valid_o    = (count != '0);
  assign trace_pc_o       = head.rec.pc;
  assign trace_instr_o    = head.rec.instr;
  assign trace_reg_addr_o = head.rec.reg_addr;
  assign trace_reg_data_o = head.rec.reg_data;
  assign trace_mem_addr_o = head.rec.mem_addr;
  assign trace_mem_data_o = head.rec.mem_data;
  assign trace_mem_wrt_o  = head.rec.mem_wrt;
  assign trace_mem_read_o = head.rec.mem_read;
  assign trace_seq_o      = head.seq;
  assign count_o          = count;
  assign overflow_o       = overflow;
  assign drop_cnt_o       = drop_cnt;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - scoreboard bench for retire_trace_buffer
module tb_retire_trace_buffer;
  import riscv_pkg::*;

  localparam int DEPTH    = 16;
  localparam int DROP_W   = 2;
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic clk = 1'b0, rstn = 1'b0, clear = 1'b0, update = 1'b0, ready = 1'b0;
  retire_rec_t rec_in = '0;
  logic                   t_valid, t_wrt, t_read, t_ovf;
  logic [XLEN-1:0]        t_pc, t_instr, t_rdata, t_maddr, t_mdata;
  logic [4:0]             t_raddr;
  logic [31:0]            t_seq;
  logic [CW-1:0]          t_count;
  logic [DROP_W-1:0]      t_drops;

  retire_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear), .update_i(update),
    .pc_i(rec_in.pc), .instr_i(rec_in.instr), .reg_data_i(rec_in.reg_data),
    .mem_addr_i(rec_in.mem_addr), .mem_data_i(rec_in.mem_data),
    .reg_addr_i(rec_in.reg_addr), .mem_wrt_i(rec_in.mem_wrt), .mem_read_i(rec_in.mem_read),
    .trace_valid_o(t_valid), .trace_ready_i(ready),
    .trace_pc_o(t_pc), .trace_instr_o(t_instr), .trace_reg_data_o(t_rdata),
    .trace_mem_addr_o(t_maddr), .trace_mem_data_o(t_mdata), .trace_reg_addr_o(t_raddr),
    .trace_mem_wrt_o(t_wrt), .trace_mem_read_o(t_read), .trace_seq_o(t_seq),
    .count_o(t_count), .overflow_o(t_ovf), .drop_cnt_o(t_drops)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  trace_entry_t sb[$];
  int           occ_m = 0, drops_m = 0;
  logic [31:0]  seq_m = '0;
  logic         ovf_m = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic retire_rec_t rand_rec();
    retire_rec_t r;
    r.pc = $urandom; r.instr = $urandom; r.reg_addr = 5'($urandom_range(0, 31));
    r.reg_data = $urandom; r.mem_addr = $urandom; r.mem_data = $urandom;
    r.mem_wrt = 1'($urandom_range(0, 1)); r.mem_read = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic model_reset();
    sb.delete(); occ_m = 0; seq_m = '0; drops_m = 0; ovf_m = 1'b0;
  endtask

  // Drives one cycle; expected entries go to the scoreboard now, scalar state commits after the edge.
  task automatic cycle(input logic upd, input logic rdy, input logic clr, input retire_rec_t r);
    int occ_n, drops_n; logic [31:0] seq_n; logic ovf_n; bit pop_m, push_m;
    update = upd; clear = clr; ready = clr ? 1'b0 : rdy; rec_in = r;
    occ_n = occ_m; drops_n = drops_m; seq_n = seq_m; ovf_n = ovf_m;
    if (clr) begin
      sb.delete(); occ_n = 0; drops_n = 0; seq_n = '0; ovf_n = 1'b0;
    end else begin
      pop_m  = (occ_m > 0) && rdy;
      push_m = upd && ((occ_m < DEPTH) || pop_m);
      if (push_m) sb.push_back('{rec: r, seq: seq_m});
      if (upd && !push_m) begin
        ovf_n = 1'b1;
        if (drops_n < DROP_MAX) drops_n++;
      end
      if (upd) seq_n = seq_m + 1;
      occ_n = occ_m + int'(push_m) - int'(pop_m);
    end
    @(posedge clk); #1;
    occ_m = occ_n; drops_m = drops_n; seq_m = seq_n; ovf_m = ovf_n;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      trace_entry_t exp_e, act_e;
      check("count", t_count, occ_m);
      check("valid", t_valid, occ_m != 0);
      check("overflow", t_ovf, ovf_m);
      check("drop_cnt", t_drops, drops_m);
      if (t_valid && ready) begin
        act_e = {t_pc, t_instr, t_raddr, t_rdata, t_maddr, t_mdata, t_wrt, t_read, t_seq};
        if (sb.size() == 0) begin
          check("pop_with_empty_scoreboard", 1, 0);
        end else begin
          exp_e = sb.pop_front();
          check("entry", act_e, exp_e);
        end
      end
    end
  end

  initial begin
    retire_rec_t r;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    check("reset_valid", t_valid, 0);
    check("reset_count", t_count, 0);
    check("reset_pc", t_pc, 0);
    check("reset_seq", t_seq, 0);
    check("reset_drops", t_drops, 0);

    for (int i = 0; i < 3; i++) begin
      r = rand_rec(); r.pc = 32'h8000_0000 + 32'(4 * i);
      cycle(1, 1, 0, r);
    end
    repeat (3) cycle(0, 1, 0, rand_rec());
    check("drained_valid", t_valid, 0);

    for (int i = 0; i < DEPTH + 6; i++) cycle(1, 0, 0, rand_rec());
    check("full_count", t_count, DEPTH);
    check("saturated_drops", t_drops, DROP_MAX);
    repeat (5) cycle(1, 1, 0, rand_rec());
    check("full_pushpop_count", t_count, DEPTH);
    repeat (DEPTH - 7) cycle(0, 1, 0, rand_rec());
    check("held_seven", t_count, 7);
    cycle(1, 1, 1, rand_rec());
    check("clear_count", t_count, 0);
    check("clear_overflow", t_ovf, 0);
    cycle(1, 1, 0, rand_rec());
    repeat (2) cycle(0, 1, 0, rand_rec());

    repeat (4) cycle(1, 0, 0, rand_rec());
    update = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("async_reset_valid", t_valid, 0);
    check("async_reset_count", t_count, 0);
    model_reset();
    @(posedge clk); #1 rstn = 1'b1;

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < ((i / 100) % 2 ? 8 : 4),
            $urandom_range(0, 199) == 0, rand_rec());
    end
    for (int i = 0; i < DEPTH + 4 && occ_m > 0; i++) cycle(0, 1, 0, rand_rec());
    check("drain_done", occ_m, 0);

    force dut.seq = 32'hFFFF_FFFF;
    #1 release dut.seq;
    seq_m = 32'hFFFF_FFFF;
    repeat (2) cycle(1, 1, 0, rand_rec());
    repeat (3) cycle(0, 1, 0, rand_rec());

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
